// File: rtl/fractal_stream_colorizer.sv
// Colorizes a fractal iteration-count stream into 24-bit RGB and re-emits it as an
// AXI4-Stream video master, resynchronising to the next frame start after any overflow.
module fractal_stream_colorizer #(
  parameter int DEPTH    = 512,
  parameter int MAX_ITER = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  s_data,
  input  logic        s_frame_start,
  input  logic        s_line_end,
  input  logic        s_data_enable,
  output logic [23:0] m_axis_tdata,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        overflow,
  output logic [15:0] drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0]  MAX_ITER_B = 8'(MAX_ITER);
  localparam logic [CW:0] DEPTH_W    = (CW+1)'(DEPTH);

  typedef enum logic [0:0] {SYNC, RUN} state_t;

  typedef struct packed {
    logic        user;
    logic        last;
    logic [23:0] rgb;
  } pix_t;

  state_t          state;
  logic            s1_valid;
  pix_t            s1_pix;
  pix_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   occ;

  logic            full;
  logic            accept;
  logic            run_drop;
  logic            sync_drop;
  logic [CW:0]     pending;
  logic [CW-1:0]   mem_count;
  logic            pop;
  logic            load_out;
  logic            mem_rd;
  logic            mem_wr;
  logic            bypass;

  function automatic logic [23:0] colormap(input logic [7:0] d);
    logic [7:0] g;
    g = d[7] ? 8'hFF : {d[6:0], 1'b0};
    if (d == MAX_ITER_B) return 24'h000000;
    return {d, g, ~d};
  endfunction

  // The beat already sitting in stage 1 is counted as occupied, so it always has a slot.
  assign pending = {1'b0, occ} + (CW+1)'(s1_valid);
  assign full    = (pending >= DEPTH_W);

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    accept    = 1'b0;
    run_drop  = 1'b0;
    sync_drop = 1'b0;
    if (s_data_enable) begin
      case (state)
        SYNC: begin
          if (s_frame_start) begin
            if (full) sync_drop = 1'b1;
            else      accept    = 1'b1;
          end
        end
        RUN: begin
          if (full) run_drop = 1'b1;
          else      accept   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= SYNC;
      overflow   <= 1'b0;
      drop_count <= 16'h0000;
    end else begin
      if (accept) state <= RUN;
      if (run_drop) begin
        state    <= SYNC;
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
      if (sync_drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_pix   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_pix.user <= s_frame_start;
        s1_pix.last <= s_line_end;
        s1_pix.rgb  <= colormap(s_data);
      end
    end
  end

  // The output register is the FIFO head; the memory only holds entries behind it.
  assign pop       = m_axis_tvalid && m_axis_tready;
  assign load_out  = !m_axis_tvalid || pop;
  assign mem_count = occ - CW'(m_axis_tvalid);
  assign mem_rd    = load_out && (mem_count != '0);
  assign bypass    = load_out && (mem_count == '0) && s1_valid;
  assign mem_wr    = s1_valid && !bypass;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 24'h000000;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      occ           <= '0;
    end else begin
      occ <= occ + CW'(s1_valid) - CW'(pop);
      if (mem_wr) wr_ptr <= wr_ptr + AW'(1);
      if (load_out) begin
        if (mem_rd) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tuser  <= mem[rd_ptr].user;
          m_axis_tlast  <= mem[rd_ptr].last;
          m_axis_tdata  <= mem[rd_ptr].rgb;
          rd_ptr        <= rd_ptr + AW'(1);
        end else if (bypass) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tuser  <= s1_pix.user;
          m_axis_tlast  <= s1_pix.last;
          m_axis_tdata  <= s1_pix.rgb;
        end else begin
          m_axis_tvalid <= 1'b0;
        end
      end
    end
  end

  // NOTE: the storage array has no reset; the pointers and occupancy alone define validity.
  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr] <= s1_pix;
  end

endmodule

// File: tb/tb_fractal_stream_colorizer.sv
// Scoreboard bench for fractal_stream_colorizer: the driver queues expected beats,
// and a monitor compares them against every output transfer.
module tb_fractal_stream_colorizer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  s_data;
  logic        s_frame_start;
  logic        s_line_end;
  logic        s_data_enable;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        overflow;
  logic [15:0] drop_count;

  int checks   = 0;
  int failures = 0;
  logic [25:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [25:0] stall_beat = '0;
  bit          rnd_on;

  fractal_stream_colorizer #(.DEPTH(DEPTH), .MAX_ITER(255)) dut (
    .clk(clk), .resetn(resetn),
    .s_data(s_data), .s_frame_start(s_frame_start), .s_line_end(s_line_end),
    .s_data_enable(s_data_enable),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] cmap(input logic [7:0] d);
    logic [7:0] g;
    if (d == 8'd255) return 24'h000000;
    g = (d >= 8'd128) ? 8'd255 : 8'(2 * d);
    return {d, g, 8'd255 - d};
  endfunction

  // Monitor: compare each transfer with the queue head, and check stability under stall.
  always @(negedge clk) begin
    logic [25:0] got;
    logic [25:0] exp;
    got = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    if (!resetn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(m_axis_tvalid), 32'd1);
        check("hold_data", 32'(got), 32'(stall_beat));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got %0h expected none", got);
        end else begin
          exp = exp_q.pop_front();
          check("beat", 32'(got), 32'(exp));
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_beat = got;
    end
  end

  task automatic beat(input logic [7:0] d, input logic fs, input logic le,
                      input bit acc, input logic [23:0] rgb);
    s_data        = d;
    s_frame_start = fs;
    s_line_end    = le;
    s_data_enable = 1'b1;
    if (acc) exp_q.push_back({fs, le, rgb});
    @(posedge clk);
    #1;
    s_data_enable = 1'b0;
    s_frame_start = 1'b0;
    s_line_end    = 1'b0;
  endtask

  task automatic idle(input int n);
    s_data_enable = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    idle(3);
    check({name, "_idle_valid"}, 32'(m_axis_tvalid), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    s_data = '0; s_frame_start = 1'b0; s_line_end = 1'b0; s_data_enable = 1'b0;
    m_axis_tready = 1'b1;
    rnd_on = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check("rst_tuser", 32'(m_axis_tuser), 32'd0);
    check("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Beats before the first frame start are discarded.
    for (int i = 0; i < 3; i++) beat(8'd50, 1'b0, 1'b0, 1'b0, 24'h0);
    fork
      begin
        @(posedge clk); @(negedge clk);
        check("lat_n1_tvalid", 32'(m_axis_tvalid), 32'd0);
        @(posedge clk); @(negedge clk);
        check("lat_n2_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("lat_n2_tuser", 32'(m_axis_tuser), 32'd1);
      end
    join_none
    beat(8'd0,   1'b1, 1'b0, 1'b1, 24'h0000FF);
    beat(8'd100, 1'b0, 1'b0, 1'b1, 24'h64C89B);
    beat(8'd200, 1'b0, 1'b0, 1'b1, 24'hC8FF37);
    beat(8'd255, 1'b0, 1'b1, 1'b1, 24'h000000);
    beat(8'd1,   1'b0, 1'b0, 1'b1, 24'h0102FE);
    beat(8'd127, 1'b0, 1'b0, 1'b1, 24'h7FFE80);
    beat(8'd128, 1'b0, 1'b0, 1'b1, 24'h80FF7F);
    beat(8'd254, 1'b0, 1'b1, 1'b1, 24'hFEFF01);
    wait_drain("frame1");

    // Backpressure: eight beats fill DEPTH=8 exactly with no loss.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 8; i++)
      beat(8'(10 + i), 1'(i == 0), 1'(i % 4 == 3), 1'b1, cmap(8'(10 + i)));
    idle(5);
    check("bp_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("bp_head_tdata", 32'(m_axis_tdata), 32'h0A14F5);
    m_axis_tready = 1'b1;
    wait_drain("backpressure");
    check("bp_overflow", 32'(overflow), 32'd0);
    check("bp_drop_count", 32'(drop_count), 32'd0);

    // Overflow: beat 8 finds the FIFO full, the rest of the frame is dropped.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 12; i++)
      beat(8'(20 + i), 1'(i == 0), 1'(i % 4 == 3), 1'(i < 8), cmap(8'(20 + i)));
    idle(3);
    check("ovf_overflow", 32'(overflow), 32'd1);
    check("ovf_drop_count", 32'(drop_count), 32'd1);
    m_axis_tready = 1'b1;
    wait_drain("ovf_drain");
    for (int i = 0; i < 8; i++)
      beat(8'(40 + i), 1'(i == 0), 1'(i % 4 == 3), 1'b1, cmap(8'(40 + i)));
    wait_drain("ovf_resume");

    // Random ready over three 16x4 frames with generator-style gaps.
    rnd_on = 1'b1;
    fork
      begin
        int zero_run = 0;
        while (rnd_on) begin
          @(posedge clk);
          #1;
          if (zero_run >= 3) m_axis_tready = 1'b1;
          else               m_axis_tready = 1'($urandom_range(0, 1));
          zero_run = m_axis_tready ? 0 : zero_run + 1;
        end
      end
      begin
        for (int f = 0; f < 3; f++)
          for (int l = 0; l < 4; l++) begin
            for (int p = 0; p < 16; p++) begin
              logic [7:0] d;
              d = 8'($urandom_range(0, 255));
              if (p == 5 && l == 1) d = 8'd255;
              beat(d, 1'(l == 0 && p == 0), 1'(p == 15), 1'b1, cmap(d));
              idle(4);
            end
            idle(6);
          end
        rnd_on = 1'b0;
      end
    join
    m_axis_tready = 1'b1;
    wait_drain("random");
    check("rnd_overflow_sticky", 32'(overflow), 32'd1);
    check("rnd_drop_count", 32'(drop_count), 32'd1);

    // Reset mid-frame with a stalled, non-empty FIFO.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++)
      beat(8'(60 + i), 1'(i == 0), 1'(i == 3), 1'b1, cmap(8'(60 + i)));
    idle(2);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("mid_rst_tdata", 32'(m_axis_tdata), 32'd0);
    check("mid_rst_tuser", 32'(m_axis_tuser), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_drop_count", 32'(drop_count), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) beat(8'(70 + i), 1'b0, 1'(i == 2), 1'b0, 24'h0);
    for (int i = 0; i < 8; i++)
      beat(8'(80 + i), 1'(i == 0), 1'(i % 4 == 3), 1'b1, cmap(8'(80 + i)));
    wait_drain("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
